// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl
//   Single-port unified memory controller. It shares one byte-wide synchronous
//   RAM between the CPU's instruction-fetch port and its data port. Data has
//   priority, and an "owed" flag alternates the grant when both ports contend,
//   so neither port can starve.
//
//   A fetch reads two consecutive bytes, {mem[a+1], mem[a]}, in two
//   uninterruptible beats. Every beat lasts 1+WAIT cycles.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low; clears all control state and read regs
//   i_req    fetch request (level, held until i_ready)
//   i_addr   fetch byte address
//   i_rdata  fetched halfword {mem[a+1], mem[a]}
//   i_ready  one-cycle fetch-complete pulse
//   d_req    data request (level, held until d_ready)
//   d_we     1 = write, 0 = read
//   d_addr   data address
//   d_wdata  write data
//   d_rdata  read data
//   d_ready  one-cycle data-complete pulse
//   busy     high whenever the controller is not idle
module unified_mem_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 2**ADDR_W,
    parameter int WAIT      = 0,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [2*DATA_W-1:0] i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] D_ACC = 2'd1;
    localparam logic [1:0] I_LO  = 2'd2;
    localparam logic [1:0] I_HI  = 2'd3;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [3:0]        beatCnt;
    logic              owed;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              iElig;
    logic              dElig;
    logic              grantD;
    logic              grantI;
    logic              lastBeat;
    logic              inRange;
    logic              memWe;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdVal;

    // A request seen in the same cycle as its own ready pulse is ignored.
    // This keeps a held-high req from being re-granted for the access that
    // just finished.
    assign iElig  = i_req && !i_ready;
    assign dElig  = d_req && !d_ready;
    assign grantD = (state == IDLE) && dElig && (!iElig || !owed);
    assign grantI = (state == IDLE) && iElig && !grantD;

    assign lastBeat = (beatCnt == 4'(WAIT));
    assign busy     = (state != IDLE);

    // One shared read address, selected by the beat that is currently active.
    always_comb begin
        rdAddr = i_addr;
        case (state)
            D_ACC:   rdAddr = d_addr;
            I_HI:    rdAddr = i_addr + ADDR_W'(1);
            default: rdAddr = i_addr;
        endcase
    end

    assign inRange = ({1'b0, rdAddr} < DEPTH_L);
    assign rdVal   = inRange ? mem[rdAddr[IDX_W-1:0]] : '0;
    assign memWe   = (state == D_ACC) && lastBeat && d_we && inRange;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[rdAddr[IDX_W-1:0]] <= d_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            beatCnt <= '0;
            owed    <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    beatCnt <= '0;
                    if (grantD) begin
                        state <= D_ACC;
                        // Fetch was passed over, so it wins the next tie.
                        owed  <= iElig;
                    end else if (grantI) begin
                        state <= I_LO;
                        owed  <= 1'b0;
                    end
                end
                D_ACC: begin
                    if (lastBeat) begin
                        beatCnt <= '0;
                        state   <= IDLE;
                        d_ready <= 1'b1;
                        if (!d_we) begin
                            d_rdata <= rdVal;
                        end
                    end else begin
                        beatCnt <= beatCnt + 4'd1;
                    end
                end
                I_LO: begin
                    if (lastBeat) begin
                        beatCnt               <= '0;
                        state                 <= I_HI;
                        i_rdata[DATA_W-1:0]   <= rdVal;
                    end else begin
                        beatCnt <= beatCnt + 4'd1;
                    end
                end
                I_HI: begin
                    if (lastBeat) begin
                        beatCnt                      <= '0;
                        state                        <= IDLE;
                        i_ready                      <= 1'b1;
                        i_rdata[2*DATA_W-1:DATA_W]   <= rdVal;
                    end else begin
                        beatCnt <= beatCnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
